// File: rtl/delay_timeout_pkg.sv
// Shared constants for the delay/timeout watchdog used by the clock controller.
package delay_timeout_pkg;

  localparam int DEFAULT_DELAY = 8;
  localparam int MODE_LEVEL    = 0;
  localparam int MODE_PULSE    = 1;

endpackage

// File: rtl/delay_timeout_sat_counter.sv
// Saturating up-counter with clear priority; never wraps past MAX.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_r;

  // Count register: clear wins over increment, increment stops at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != MAX_V)) begin
      count_r <= count_r + WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count  = count_r;
  assign at_max = (count_r == MAX_V);

endmodule

// File: rtl/delay_timeout.sv
// Watchdog: raises out after in1 & in2 have been high for DELAY consecutive edges.
module delay_timeout
  import delay_timeout_pkg::*;
#(
  parameter int DELAY      = DEFAULT_DELAY,
  parameter int PULSE_MODE = MODE_LEVEL,
  parameter int CNT_W      = $clog2(DELAY + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in1,
  input  logic in2,
  output logic out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

  logic             cond_s;
  logic             at_max_s;
  logic [CNT_W-1:0] cnt_s;
  logic             expire_s;
  logic             out_r;
  logic             armed_r;

  assign cond_s = in1 & in2;

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (DELAY - 1)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~cond_s),
    .inc    (cond_s),
    .count  (cnt_s),
    .at_max (at_max_s)
  );

  // The counter already sits at DELAY-1, so this edge is the DELAY-th high sample.
  assign expire_s = cond_s & at_max_s & (cnt_s == LAST);

  // Output and re-arm flag; a low condition always clears and re-arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r   <= 1'b0;
      armed_r <= 1'b1;
    end else if (!cond_s) begin
      out_r   <= 1'b0;
      armed_r <= 1'b1;
    end else if (expire_s) begin
      out_r   <= (PULSE_MODE == MODE_PULSE) ? armed_r : 1'b1;
      armed_r <= 1'b0;
    end else begin
      out_r   <= 1'b0;
      armed_r <= armed_r;
    end
  end

  assign out = out_r;

endmodule

// File: tb/tb_delay_timeout.sv
// Randomized self-checking bench: four delay_timeout configurations vs a run-length model.
module tb_delay_timeout;

  localparam int N = 4;
  localparam int DLY [N] = '{8, 3, 1, 1};
  localparam int PLS [N] = '{0, 1, 0, 1};

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in1_v;
  logic [N-1:0] in2_v;
  logic [N-1:0] out_v;

  int run_len [N];
  int errs;
  int checks;

  delay_timeout #(.DELAY(8), .PULSE_MODE(0)) u_d8_lvl (
    .clk(clk), .rst_n(rst_n), .in1(in1_v[0]), .in2(in2_v[0]), .out(out_v[0]));
  delay_timeout #(.DELAY(3), .PULSE_MODE(1)) u_d3_pls (
    .clk(clk), .rst_n(rst_n), .in1(in1_v[1]), .in2(in2_v[1]), .out(out_v[1]));
  delay_timeout #(.DELAY(1), .PULSE_MODE(0)) u_d1_lvl (
    .clk(clk), .rst_n(rst_n), .in1(in1_v[2]), .in2(in2_v[2]), .out(out_v[2]));
  delay_timeout #(.DELAY(1), .PULSE_MODE(1)) u_d1_pls (
    .clk(clk), .rst_n(rst_n), .in1(in1_v[3]), .in2(in2_v[3]), .out(out_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Level mode: out once the run of high samples reaches DELAY; pulse mode: only on that edge.
  function automatic int model_out(input int i);
    if (PLS[i] == 1) return (run_len[i] == DLY[i]) ? 1 : 0;
    return (run_len[i] >= DLY[i]) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++)
      check_eq($sformatf("%s.u%0d", tag, i), 32'(out_v[i]), 32'(model_out(i)));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst_n) run_len[i] = 0;
      else if (in1_v[i] && in2_v[i]) run_len[i] = run_len[i] + 1;
      else run_len[i] = 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_all(input logic a, input logic b);
    in1_v = {N{a}};
    in2_v = {N{b}};
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    for (int i = 0; i < N; i++) run_len[i] = 0;
    rst_n = 1'b0;
    set_all(1'b0, 1'b0);
    #1;
    check_all("reset");
    step("reset_hold");
    rst_n = 1'b1;

    // Hold condition: level rises after edge 8 and holds 20 more; D3 pulse fires once.
    set_all(1'b1, 1'b1);
    for (int k = 0; k < 28; k++) step("hold");

    // Asynchronous reset while out is high.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) run_len[i] = 0;
    #1;
    check_all("async_rst");
    step("in_rst");
    step("in_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step("after_rst");

    // One-cycle low on in2 after edge 5 restarts the count.
    set_all(1'b0, 1'b0);
    step("drop");
    set_all(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step("pre_glitch");
    in2_v = {N{1'b0}};
    step("glitch");
    in2_v = {N{1'b1}};
    for (int k = 0; k < 10; k++) step("post_glitch");

    // Drop in1 after expiry, then re-raise.
    in1_v = {N{1'b0}};
    step("in1_low");
    in1_v = {N{1'b1}};
    for (int k = 0; k < 10; k++) step("rearm");

    // Toggle condition every cycle.
    for (int k = 0; k < 12; k++) begin
      set_all(k[0], 1'b1);
      step("toggle");
    end

    // Random inputs biased high so long runs occur.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        in1_v[i] = ($urandom_range(15, 0) != 0);
        in2_v[i] = ($urandom_range(15, 0) != 0);
      end
      if ($urandom_range(199, 0) == 0) begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) run_len[i] = 0;
        #1;
        check_all("rnd_rst");
        step("rnd_in_rst");
        rst_n = 1'b1;
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
